// File: rtl/ws2812b_decoder.sv
// ws2812b_decoder: decodes a WS2812B serial line into 24-bit GRB pixels with frame latch detection.
// Ports:
//   clk          20 MHz clock
//   reset        asynchronous active-high reset
//   led_in       asynchronous WS2812B serial line
//   data_out     decoded pixel, first-received bit in [23]
//   valid/ready  output handshake for data_out
//   latch        one-cycle pulse at frame end
//   pixel_count  complete pixels in the frame just latched
//   error        one-cycle pulse on timing violation or partial pixel
//   overrun      one-cycle pulse when a pixel is dropped while valid is pending
module ws2812b_decoder #(
    parameter int T_THRESH     = 12,
    parameter int T_MIN_HIGH   = 3,
    parameter int T_MAX_HIGH   = 40,
    parameter int LATCH_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        led_in,
    input  logic        ready,
    output logic [23:0] data_out,
    output logic        valid,
    output logic        latch,
    output logic [8:0]  pixel_count,
    output logic        error,
    output logic        overrun
);
    localparam int HW = $clog2(T_MAX_HIGH + 1);
    localparam int LW = $clog2(LATCH_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, STUCK} state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q, prev_q;
    logic [HW-1:0] hcnt_q, hcnt_d, hcnt_inc;
    logic [LW-1:0] lcnt_q, lcnt_d, lcnt_inc;
    logic [23:0]   shreg_q, shreg_d;
    logic [4:0]    bit_count_q, bit_count_d;
    logic [8:0]    pixel_cnt_q, pixel_cnt_d;
    logic [23:0]   data_out_q, data_out_d;
    logic          valid_q, valid_d;
    logic          latch_q, latch_d;
    logic [8:0]    pixel_count_q, pixel_count_d;
    logic          error_q, error_d;
    logic          overrun_q, overrun_d;
    logic          rise, fall;

    assign rise     = sync2_q & ~prev_q;
    assign fall     = ~sync2_q & prev_q;
    assign hcnt_inc = hcnt_q + 1'b1;
    assign lcnt_inc = lcnt_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        hcnt_d        = hcnt_q;
        lcnt_d        = lcnt_q;
        shreg_d       = shreg_q;
        bit_count_d   = bit_count_q;
        pixel_cnt_d   = pixel_cnt_q;
        data_out_d    = data_out_q;
        valid_d       = valid_q & ~ready;
        latch_d       = 1'b0;
        pixel_count_d = pixel_count_q;
        error_d       = 1'b0;
        overrun_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                    hcnt_d  = HW'(1);
                end
            end
            HIGH: begin
                if (fall) begin
                    state_d = LOW;
                    lcnt_d  = LW'(1);
                    if (hcnt_q < HW'(T_MIN_HIGH)) begin
                        error_d     = 1'b1;
                        bit_count_d = 5'd0;
                    end else begin
                        shreg_d     = {shreg_q[22:0], hcnt_q >= HW'(T_THRESH)};
                        bit_count_d = bit_count_q + 5'd1;
                    end
                end else if (hcnt_inc == HW'(T_MAX_HIGH)) begin
                    // hcnt stops here, so it can never wrap while the line is stuck high
                    state_d     = STUCK;
                    hcnt_d      = hcnt_inc;
                    error_d     = 1'b1;
                    bit_count_d = 5'd0;
                end else begin
                    hcnt_d = hcnt_inc;
                end
            end
            STUCK: begin
                if (fall) begin
                    state_d = LOW;
                    lcnt_d  = LW'(1);
                end
            end
            LOW: begin
                if (rise) begin
                    state_d = HIGH;
                    hcnt_d  = HW'(1);
                end else if (lcnt_inc == LW'(LATCH_CYCLES)) begin
                    state_d       = IDLE;
                    lcnt_d        = lcnt_inc;
                    latch_d       = 1'b1;
                    pixel_count_d = pixel_cnt_q;
                    pixel_cnt_d   = 9'd0;
                    if (bit_count_q != 5'd0) begin
                        error_d     = 1'b1;
                        bit_count_d = 5'd0;
                    end
                end else begin
                    lcnt_d = lcnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
        // A full pixel is handed off one cycle after its last bit lands in the shift register
        if (bit_count_q == 5'd24) begin
            bit_count_d = 5'd0;
            pixel_cnt_d = (pixel_cnt_q == 9'd511) ? pixel_cnt_q : pixel_cnt_q + 9'd1;
            if (valid_q && !ready) begin
                overrun_d = 1'b1;
            end else begin
                valid_d    = 1'b1;
                data_out_d = shreg_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            prev_q        <= 1'b0;
            hcnt_q        <= '0;
            lcnt_q        <= '0;
            shreg_q       <= '0;
            bit_count_q   <= '0;
            pixel_cnt_q   <= '0;
            data_out_q    <= '0;
            valid_q       <= 1'b0;
            latch_q       <= 1'b0;
            pixel_count_q <= '0;
            error_q       <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= led_in;
            sync2_q       <= sync1_q;
            prev_q        <= sync2_q;
            hcnt_q        <= hcnt_d;
            lcnt_q        <= lcnt_d;
            shreg_q       <= shreg_d;
            bit_count_q   <= bit_count_d;
            pixel_cnt_q   <= pixel_cnt_d;
            data_out_q    <= data_out_d;
            valid_q       <= valid_d;
            latch_q       <= latch_d;
            pixel_count_q <= pixel_count_d;
            error_q       <= error_d;
            overrun_q     <= overrun_d;
        end
    end

    assign data_out    = data_out_q;
    assign valid       = valid_q;
    assign latch       = latch_q;
    assign pixel_count = pixel_count_q;
    assign error       = error_q;
    assign overrun     = overrun_q;
endmodule
